serv_bus_arbiter: RTL

- Shares one Wishbone master port toward common instruction/data memory between the SERV core's instruction bus (ibus) and data bus (dbus).
- Sits between `serv_rf_top` and the memory/peripheral fabric inside `user_project_wrapper`.
- Provides round-robin grant, registered response return and a bus-timeout watchdog, so a missing slave can never hang the core.

---
 rtl/serv_arb_pkg.sv | 20 ++
 rtl/serv_arb_timeout.sv | 33 +++
 rtl/serv_bus_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serv_arb_pkg.sv
// Shared encodings and constants for the SERV ibus/dbus Wishbone arbiter.
package serv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/serv_arb_timeout.sv
// Saturating wait counter for the arbiter watchdog; expired marks the last
// wait cycle a granted transfer is allowed before forced completion.
module serv_arb_timeout
    import serv_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The counter holds the number of busy cycles already elapsed, so the
    // cycle in which it equals TIMEOUT-1 is the TIMEOUT-th cycle of waiting.
    localparam cnt_t LIMIT = cnt_t'(TIMEOUT - 1);

    cnt_t count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg >= LIMIT);

endmodule

// File: rtl/serv_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between SERV's ibus
// and dbus, with registered responses and a watchdog against missing slaves.
module serv_bus_arbiter
    import serv_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    state_t state_reg;
    grant_t last_grant_reg;
    logic   tmo_clr;
    logic   tmo_en;
    logic   tmo_expired;
    logic   pick_ibus;

    assign tmo_clr = (state_reg == ST_IDLE);
    assign tmo_en  = (state_reg == ST_BUSY_I) || (state_reg == ST_BUSY_D);

    // ibus wins when alone, or on a tie when dbus held the previous grant.
    assign pick_ibus = i_ibus_cyc && (!i_dbus_cyc || (last_grant_reg == GNT_D));

    serv_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (i_rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GNT_D;
            o_ibus_rdt     <= '0;
            o_ibus_ack     <= 1'b0;
            o_dbus_rdt     <= '0;
            o_dbus_ack     <= 1'b0;
            o_wb_adr       <= '0;
            o_wb_dat       <= '0;
            o_wb_sel       <= '0;
            o_wb_we        <= 1'b0;
            o_wb_cyc       <= 1'b0;
            o_wb_stb       <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
            o_timeout  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_ibus) begin
                        o_wb_adr  <= i_ibus_adr;
                        o_wb_dat  <= '0;
                        o_wb_sel  <= 4'hF;
                        o_wb_we   <= 1'b0;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        state_reg <= ST_BUSY_I;
                    end else if (i_dbus_cyc) begin
                        o_wb_adr  <= i_dbus_adr;
                        o_wb_dat  <= i_dbus_dat;
                        o_wb_sel  <= i_dbus_sel;
                        o_wb_we   <= i_dbus_we;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        state_reg <= ST_BUSY_D;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // A real ack takes precedence over an expiring watchdog.
                    if (i_wb_ack || tmo_expired) begin
                        o_wb_cyc  <= 1'b0;
                        o_wb_stb  <= 1'b0;
                        o_timeout <= !i_wb_ack;
                        state_reg <= ST_DONE;
                        if (state_reg == ST_BUSY_I) begin
                            o_ibus_rdt <= i_wb_ack ? i_wb_rdt : 32'h0;
                            o_ibus_ack <= 1'b1;
                        end else begin
                            o_dbus_rdt <= i_wb_ack ? i_wb_rdt : 32'h0;
                            o_dbus_ack <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    last_grant_reg <= o_dbus_ack ? GNT_D : GNT_I;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
